// File: rtl/am2940_multi_pkg.sv
// Shared opcodes, mode encodings and control-register bit positions for the
// multi-channel Am2940-style address generator.
package am2940_pkg;

   localparam logic [2:0] I_WRCR   = 3'b000;
   localparam logic [2:0] I_RDCR   = 3'b001;
   localparam logic [2:0] I_RDWC   = 3'b010;
   localparam logic [2:0] I_RDAC   = 3'b011;
   localparam logic [2:0] I_REINIT = 3'b100;
   localparam logic [2:0] I_LDAD   = 3'b101;
   localparam logic [2:0] I_LDWC   = 3'b110;
   localparam logic [2:0] I_ENCT   = 3'b111;

   localparam logic [1:0] M_WCDEC  = 2'd0;
   localparam logic [1:0] M_WCINC  = 2'd1;
   localparam logic [1:0] M_ADRCMP = 2'd2;
   localparam logic [1:0] M_FREE   = 2'd3;

   localparam int CR_MODE_LO = 0;
   localparam int CR_MODE_HI = 1;
   localparam int CR_DEC     = 2;
   localparam int CR_RLD     = 3;

endpackage

// File: rtl/am2940_multi_if.sv
// Microsequencer-side bus of the address generator: instruction/channel
// select in, read data, address and carries out.
interface am2940_multi_if #(
   parameter int W   = 8,
   parameter int CH  = 4,
   parameter int CHB = (CH > 1) ? $clog2(CH) : 1
);
   logic [2:0]     instr;
   logic [CHB-1:0] ch_sel;
   logic [W-1:0]   data_in;
   logic           acineg;
   logic           wcineg;
   logic [W-1:0]   data_out;
   logic [W-1:0]   addr_out;
   logic           aconeg;
   logic           wconeg;
   logic [CH-1:0]  done;

   modport master (
      output instr, ch_sel, data_in, acineg, wcineg,
      input  data_out, addr_out, aconeg, wconeg, done
   );

   modport slave (
      input  instr, ch_sel, data_in, acineg, wcineg,
      output data_out, addr_out, aconeg, wconeg, done
   );
endinterface

// File: rtl/am2940_multi_channel.sv
// One address-generator channel: control, address and word-count registers,
// the two counters, terminal-count flags and DONE decode.
module am2940_channel
   import am2940_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sel,
   input  logic [2:0]   instr,
   input  logic [W-1:0] data_in,
   input  logic         acineg,
   input  logic         wcineg,
   output logic [3:0]   cr,
   output logic [W-1:0] ac,
   output logic [W-1:0] wc,
   output logic         ac_term,
   output logic         wc_term,
   output logic         done
);

   logic [W-1:0] ar;
   logic [W-1:0] wcr;
   logic [1:0]   mode;
   logic [W-1:0] wc_reinit;
   logic [W-1:0] ac_next;
   logic [W-1:0] wc_next;

   assign mode      = cr[CR_MODE_HI:CR_MODE_LO];
   assign wc_reinit = (mode == M_WCDEC) ? wcr : '0;
   assign ac_next   = cr[CR_DEC] ? (ac - W'(1)) : (ac + W'(1));
   assign wc_next   = (mode == M_WCDEC) ? (wc - W'(1)) : (wc + W'(1));

   assign ac_term = cr[CR_DEC] ? (ac == '0) : (ac == '1);
   assign wc_term = (mode == M_WCDEC) ? (wc == '0) : (wc == '1);

   always_comb begin
      done = 1'b0;
      unique case (mode)
         M_WCDEC:  done = (wc == W'(1));
         M_WCINC:  done = (wc == wcr);
         M_ADRCMP: done = (ac == wcr);
         M_FREE:   done = 1'b0;
         default:  done = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cr  <= '0;
         ar  <= '0;
         ac  <= '0;
         wcr <= '0;
         wc  <= '0;
      end else if (sel) begin
         case (instr)
            I_WRCR: cr <= data_in[3:0];
            I_REINIT: begin
               ac <= ar;
               wc <= wc_reinit;
            end
            I_LDAD: begin
               ar <= data_in;
               ac <= data_in;
            end
            I_LDWC: begin
               wcr <= data_in;
               wc  <= (mode == M_WCDEC) ? data_in : '0;
            end
            I_ENCT: begin
               // auto-reload takes precedence over counting; carry-ins are ignored
               if (cr[CR_RLD] && done) begin
                  ac <= ar;
                  wc <= wc_reinit;
               end else begin
                  if (!acineg) ac <= ac_next;
                  if (!wcineg) wc <= wc_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/am2940_multi.sv
// CH-channel Am2940-style DMA address generator; instructions act on the
// channel picked by ch_sel, whose read data, address and carries are muxed out.
module am2940_multi
   import am2940_pkg::*;
#(
   parameter int W   = 8,
   parameter int CH  = 4,
   parameter int CHB = (CH > 1) ? $clog2(CH) : 1
) (
   input logic             clk,
   input logic             rst,
   am2940_multi_if.slave   bus
);

   logic [CH-1:0][3:0]   cr_all;
   logic [CH-1:0][W-1:0] ac_all;
   logic [CH-1:0][W-1:0] wc_all;
   logic [CH-1:0]        ac_term_all;
   logic [CH-1:0]        wc_term_all;
   logic [CH-1:0]        sel_vec;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      assign sel_vec[i] = (bus.ch_sel == CHB'(i));

      am2940_channel #(.W(W)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .sel     (sel_vec[i]),
         .instr   (bus.instr),
         .data_in (bus.data_in),
         .acineg  (bus.acineg),
         .wcineg  (bus.wcineg),
         .cr      (cr_all[i]),
         .ac      (ac_all[i]),
         .wc      (wc_all[i]),
         .ac_term (ac_term_all[i]),
         .wc_term (wc_term_all[i]),
         .done    (bus.done[i])
      );
   end

   logic [3:0]   cur_cr;
   logic [W-1:0] cur_ac;
   logic [W-1:0] cur_wc;
   logic         cur_ac_term;
   logic         cur_wc_term;

   // an out-of-range ch_sel selects nothing and reads as zero
   always_comb begin
      cur_cr      = '0;
      cur_ac      = '0;
      cur_wc      = '0;
      cur_ac_term = 1'b0;
      cur_wc_term = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (sel_vec[i]) begin
            cur_cr      = cr_all[i];
            cur_ac      = ac_all[i];
            cur_wc      = wc_all[i];
            cur_ac_term = ac_term_all[i];
            cur_wc_term = wc_term_all[i];
         end
      end
   end

   always_comb begin
      bus.data_out = '0;
      case (bus.instr)
         I_RDCR:  bus.data_out = {{(W-4){1'b0}}, cur_cr};
         I_RDWC:  bus.data_out = cur_wc;
         I_RDAC:  bus.data_out = cur_ac;
         default: bus.data_out = '0;
      endcase
   end

   assign bus.addr_out = cur_ac;
   assign bus.aconeg   = !((bus.instr == I_ENCT) && !bus.acineg && cur_ac_term);
   assign bus.wconeg   = !((bus.instr == I_ENCT) && !bus.wcineg && cur_wc_term);

endmodule

// File: doc/am2940_multi.md
Name: am2940_multi

Overview:
- Parametrised successor to the Am2940 DMA address generator: CH independent channels, each W bits wide.
- Each channel has the classic instruction set (control/address/word-count registers and counters, four modes, carry chain, DONE).
- New behaviour: per-channel auto-reload for back-to-back transfers and a synchronous reset.
- Sits between a microsequencer issuing 3-bit instructions and the memory address bus.

Parameters:
- W, 8: data, address and word-count width. Must be at least 4.
- CH, 4: number of channels.
- CHB, $clog2(CH) (1 if CH=1): width of the channel select.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  3  instruction, applied to channel ch_sel
- ch_sel  in  CHB  selected channel
- data_in  in  W  load data
- acineg  in  1  active-low address counter count enable
- wcineg  in  1  active-low word counter count enable
- data_out  out  W  read data of the selected channel
- addr_out  out  W  address counter of the selected channel
- aconeg  out  1  active-low address carry out
- wconeg  out  1  active-low word carry out
- done  out  CH  per-channel DONE

Behaviour:
- Per-channel state: CR[3:0], AR, AC, WCR, WC.
  - CR[1:0] = mode.
  - CR[2] = address decrement (0 = increment).
  - CR[3] = auto-reload enable.
- rst=1 at an edge clears every register of every channel to 0. It overrides any instruction, including one mid-count.
- After reset: done=0, data_out=0, addr_out=0, aconeg=1, wconeg=1.
- Instructions act only on channel ch_sel. Other channels hold.
  - 000 WRITE CR: CR <= data_in[3:0].
  - 001 READ CR: data_out = {0, CR}.
  - 010 READ WC: data_out = WC.
  - 011 READ AC: data_out = AC.
  - 100 REINIT: AC <= AR; WC <= WCR if mode 0, else WC <= 0.
  - 101 LOAD ADDR: AR <= data_in and AC <= data_in.
  - 110 LOAD WC: WCR <= data_in; WC <= data_in if mode 0, else WC <= 0.
  - 111 ENABLE: counts one step per clock while held (rules below).
- data_out is combinational and is 0 for any instruction other than 001/010/011.
- addr_out = AC of ch_sel, combinational, for every instruction.
- Counting on 111:
  - AC steps ±1 per CR[2] when acineg=0.
  - WC decrements in mode 0 and increments in modes 1–3, when wcineg=0.
  - Both wrap modulo 2^W.
- Carry outputs, combinational:
  - aconeg=0 iff instr=111, acineg=0 and AC is at terminal (all-ones when incrementing, 0 when decrementing).
  - wconeg=0 iff instr=111, wcineg=0 and WC is at terminal (0 in mode 0, all-ones otherwise).
- done[i] is combinational from channel i state:
  - mode 0: WC==1.
  - mode 1: WC==WCR.
  - mode 2: AC==WCR.
  - mode 3: always 0.
- Auto-reload: if 111 is issued to a channel with CR[3]=1 and done[ch]=1, that edge performs REINIT instead of counting. Carry-ins are ignored and done drops after the edge.
- Without CR[3], counting continues through done, matching the Am2940.
- Changing mode with 000 does not alter AC or WC.

Decomposition:
- Package am2940_pkg: instruction opcode constants (I_WRCR … I_ENCT), mode constants (M_WCDEC, M_WCINC, M_ADRCMP, M_FREE), CR bit indices.
- Sub-module am2940_channel: one channel's registers, counters and done logic.
- The top instantiates CH channels via generate and muxes data_out, addr_out and the carries by ch_sel.

Test Plan:
1. Reset: rst=1 for one edge after arbitrary loads -> every CR/AR/AC/WCR/WC=0, done=0000, data_out=0; rst asserted during 111 also clears.
2. Mode 0, ch 2: CR=0, LOAD WC 3, 111 for 2 clocks with acineg=wcineg=0 -> WC 3→2→1, done=0100; channels 0, 1, 3 unchanged; READ WC gives 1.
3. Mode 1, ch 1: CR=1, LOAD WC 3 (WC=0), 111 for 3 clocks -> WC 1, 2, 3; done[1]=1 only after the 3rd edge.
4. Mode 2, ch 0: CR=2, LOAD ADDR 1, LOAD WC 4, 111 for 3 clocks -> addr_out 2, 3, 4; done[0]=1; wcineg=1 holds WC while AC still counts.
5. Auto-reload, ch 3: CR=4'b1000, LOAD ADDR 0x10, LOAD WC 2, 111 once -> AC=0x11, WC=1, done[3]=1; 111 again -> AC=0x10, WC=2, done[3]=0.
6. Carry/wrap: CR=4'b0111 (mode 3, decrement), LOAD ADDR 0x00, 111 -> aconeg=0 before the edge, AC=0xFF after; acineg=1 -> AC holds, aconeg=1; done stays 0.
